// File: rtl/poly_note_manager.sv
// poly_note_manager
//   Tracks up to NUM_SLOTS falling notes across NUM_COLS columns, resolves
//   per-column key presses against an inclusive hit window, counts hits and
//   misses, and raises a sticky game_over once TOTAL_NOTES notes resolved.
// Ports
//   clk             system clock
//   rst             asynchronous active-low reset
//   start           run enable; low freezes all state
//   speed           tick period, one tick every speed+1 enabled cycles
//   rand_val        LFSR value sampled on tick (rand is a reserved word)
//   key_press       one-cycle press pulse per column
//   slot_active     per-slot live flag
//   slot_col        per-slot column, slot i at [i*CW +: CW]
//   slot_y          per-slot y, slot i at [i*Y_W +: Y_W]
//   hit_pulse       per-column successful hit pulse
//   bad_press       per-column press with no note in the window
//   miss_pulse      at least one note missed this tick
//   hits_total      cumulative hits
//   misses_total    cumulative misses
//   notes_generated notes spawned so far
//   game_over       sticky, set the cycle after hits+misses reaches TOTAL_NOTES
module poly_note_manager #(
    parameter int          NUM_SLOTS       = 4,
    parameter int          NUM_COLS        = 4,
    parameter int          Y_W             = 10,
    parameter int          Y_MAX           = 480,
    parameter int          HIT_LO          = 400,
    parameter int          HIT_HI          = 470,
    parameter int          MIN_GAP         = 40,
    parameter logic [15:0] SPAWN_THRESHOLD = 16'h8000,
    parameter int          TOTAL_NOTES     = 30,
    localparam int         CW              = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int         CNT_W           = $clog2(TOTAL_NOTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [19:0]              speed,
    input  logic [15:0]              rand_val,
    input  logic [NUM_COLS-1:0]      key_press,
    output logic [NUM_SLOTS-1:0]     slot_active,
    output logic [NUM_SLOTS*CW-1:0]  slot_col,
    output logic [NUM_SLOTS*Y_W-1:0] slot_y,
    output logic [NUM_COLS-1:0]      hit_pulse,
    output logic [NUM_COLS-1:0]      bad_press,
    output logic                     miss_pulse,
    output logic [CNT_W-1:0]         hits_total,
    output logic [CNT_W-1:0]         misses_total,
    output logic [CNT_W-1:0]         notes_generated,
    output logic                     game_over
);

    localparam int             IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [Y_W-1:0] Y_MAX_V   = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] HIT_LO_V  = Y_W'(HIT_LO);
    localparam logic [Y_W-1:0] HIT_HI_V  = Y_W'(HIT_HI);
    localparam logic [Y_W-1:0] MIN_GAP_V = Y_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] TOTAL_V = CNT_W'(TOTAL_NOTES);

    function automatic logic in_window(input logic [Y_W-1:0] y);
        return (y >= HIT_LO_V) && (y <= HIT_HI_V);
    endfunction

    logic [19:0]              tick_cnt_r;
    logic                     en_s;
    logic                     tick_s;
    logic                     done_s;
    logic [NUM_COLS-1:0]      found_s;
    logic [NUM_COLS-1:0]      hit_col_s;
    logic [NUM_COLS-1:0]      bad_col_s;
    logic [NUM_SLOTS-1:0]     hit_slot_s;
    logic [CNT_W-1:0]         hit_inc_s;
    logic [CNT_W-1:0]         miss_inc_s;
    logic                     miss_any_s;
    logic                     free_any_s;
    logic                     gap_block_s;
    logic                     spawn_s;
    logic [IDX_W-1:0]         spawn_idx_s;
    logic [NUM_SLOTS-1:0]     active_nxt_s;
    logic [NUM_SLOTS*CW-1:0]  col_nxt_s;
    logic [NUM_SLOTS*Y_W-1:0] y_nxt_s;

    // Next-state logic: hit resolution, spawn decision and per-slot movement
    always_comb begin
        en_s         = start & ~game_over;
        tick_s       = (tick_cnt_r >= speed);
        done_s       = ((hits_total + misses_total) == TOTAL_V);
        found_s      = '0;
        hit_col_s    = '0;
        bad_col_s    = '0;
        hit_slot_s   = '0;
        hit_inc_s    = '0;
        miss_inc_s   = '0;
        miss_any_s   = 1'b0;
        free_any_s   = 1'b0;
        gap_block_s  = 1'b0;
        spawn_idx_s  = '0;
        active_nxt_s = slot_active;
        col_nxt_s    = slot_col;
        y_nxt_s      = slot_y;

        // Each column picks its lowest-index in-window note; columns never share a slot.
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (key_press[c] && !found_s[c] && slot_active[s] &&
                    (slot_col[s*CW +: CW] == CW'(c)) && in_window(slot_y[s*Y_W +: Y_W])) begin
                    found_s[c]    = 1'b1;
                    hit_slot_s[s] = 1'b1;
                end else begin
                    found_s[c]    = found_s[c];
                end
            end
            hit_col_s[c] = key_press[c] & found_s[c];
            bad_col_s[c] = key_press[c] & ~found_s[c];
            hit_inc_s    = hit_inc_s + CNT_W'(hit_col_s[c]);
        end

        // Spawn decision uses the pre-cycle slot set only; scanning downward leaves the lowest free index.
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            free_any_s  = free_any_s | ~slot_active[s];
            spawn_idx_s = slot_active[s] ? spawn_idx_s : IDX_W'(s);
            gap_block_s = gap_block_s | (slot_active[s] & (slot_y[s*Y_W +: Y_W] < MIN_GAP_V));
        end
        spawn_s = tick_s && (rand_val > SPAWN_THRESHOLD) && (notes_generated < TOTAL_V) &&
                  free_any_s && !gap_block_s;

        // A hit takes priority over the tick for the same slot.
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_active[s] && hit_slot_s[s]) begin
                active_nxt_s[s] = 1'b0;
            end else if (slot_active[s] && tick_s && (slot_y[s*Y_W +: Y_W] >= Y_MAX_V)) begin
                active_nxt_s[s] = 1'b0;
                miss_inc_s      = miss_inc_s + CNT_W'(1);
                miss_any_s      = 1'b1;
            end else if (slot_active[s] && tick_s) begin
                y_nxt_s[s*Y_W +: Y_W] = slot_y[s*Y_W +: Y_W] + Y_W'(1);
            end else begin
                active_nxt_s[s] = slot_active[s];
            end

            if (spawn_s && (spawn_idx_s == IDX_W'(s))) begin
                active_nxt_s[s]       = 1'b1;
                y_nxt_s[s*Y_W +: Y_W] = '0;
                col_nxt_s[s*CW +: CW] = rand_val[CW-1:0];
            end else begin
                col_nxt_s[s*CW +: CW] = slot_col[s*CW +: CW];
            end
        end
    end

    // State and registered outputs; game_over latches independently of the run gate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r      <= 20'd0;
            slot_active     <= '0;
            slot_col        <= '0;
            slot_y          <= '0;
            hit_pulse       <= '0;
            bad_press       <= '0;
            miss_pulse      <= 1'b0;
            hits_total      <= '0;
            misses_total    <= '0;
            notes_generated <= '0;
            game_over       <= 1'b0;
        end else begin
            game_over <= game_over | done_s;
            if (en_s) begin
                tick_cnt_r      <= tick_s ? 20'd0 : tick_cnt_r + 20'd1;
                slot_active     <= active_nxt_s;
                slot_col        <= col_nxt_s;
                slot_y          <= y_nxt_s;
                hit_pulse       <= hit_col_s;
                bad_press       <= bad_col_s;
                miss_pulse      <= miss_any_s;
                hits_total      <= hits_total + hit_inc_s;
                misses_total    <= misses_total + miss_inc_s;
                notes_generated <= notes_generated + CNT_W'(spawn_s);
            end else begin
                hit_pulse       <= '0;
                bad_press       <= '0;
                miss_pulse      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_poly_note_manager.sv
module tb_poly_note_manager;

    localparam int NS   = 4;
    localparam int NC   = 4;
    localparam int YW   = 10;
    localparam int YMAX = 48;
    localparam int HLO  = 40;
    localparam int HHI  = 48;
    localparam int MGAP = 8;
    localparam int TOT  = 12;
    localparam int CW   = 2;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [19:0]       speed = 20'd0;
    logic [15:0]       rand_val = 16'd0;
    logic [NC-1:0]     key_press = '0;
    logic [NS-1:0]     slot_active;
    logic [NS*CW-1:0]  slot_col;
    logic [NS*YW-1:0]  slot_y;
    logic [NC-1:0]     hit_pulse;
    logic [NC-1:0]     bad_press;
    logic              miss_pulse;
    logic [CNTW-1:0]   hits_total;
    logic [CNTW-1:0]   misses_total;
    logic [CNTW-1:0]   notes_generated;
    logic              game_over;

    poly_note_manager #(
        .NUM_SLOTS(NS), .NUM_COLS(NC), .Y_W(YW), .Y_MAX(YMAX), .HIT_LO(HLO), .HIT_HI(HHI),
        .MIN_GAP(MGAP), .SPAWN_THRESHOLD(16'h8000), .TOTAL_NOTES(TOT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .speed(speed), .rand_val(rand_val),
        .key_press(key_press), .slot_active(slot_active), .slot_col(slot_col), .slot_y(slot_y),
        .hit_pulse(hit_pulse), .bad_press(bad_press), .miss_pulse(miss_pulse),
        .hits_total(hits_total), .misses_total(misses_total),
        .notes_generated(notes_generated), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS-1:0]    act;
        logic [NS*CW-1:0] col;
        logic [NS*YW-1:0] y;
        logic [NC-1:0]    hit;
        logic [NC-1:0]    bad;
        logic             miss;
        logic [CNTW-1:0]  hits;
        logic [CNTW-1:0]  misses;
        logic [CNTW-1:0]  gen;
        logic             go;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a list of notes with (active, column, height) plus totals.
    bit m_act[NS];
    int m_col[NS];
    int m_y[NS];
    int m_cnt, m_hits, m_misses, m_gen;
    bit m_go;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_act[s] = 0; m_col[s] = 0; m_y[s] = 0;
        end
        m_cnt = 0; m_hits = 0; m_misses = 0; m_gen = 0; m_go = 0;
    endtask

    task automatic model_step(input bit st, input int spd, input int rv,
                              input logic [NC-1:0] kp, output exp_t e);
        bit hit_slot[NS];
        bit tick;
        bit spawn;
        int free_idx;
        bit gap_ok;
        int sum;
        e = '0;
        sum = m_hits + m_misses;
        if (st && !m_go) begin
            tick = (m_cnt >= spd);
            m_cnt = tick ? 0 : m_cnt + 1;
            for (int s = 0; s < NS; s++) hit_slot[s] = 0;
            for (int c = 0; c < NC; c++) begin
                if (kp[c]) begin
                    int t;
                    t = -1;
                    for (int s = 0; s < NS; s++)
                        if (t < 0 && m_act[s] && m_col[s] == c && m_y[s] >= HLO && m_y[s] <= HHI) t = s;
                    if (t >= 0) begin
                        hit_slot[t] = 1; e.hit[c] = 1'b1; m_hits++;
                    end else begin
                        e.bad[c] = 1'b1;
                    end
                end
            end
            spawn = 0;
            free_idx = -1;
            if (tick) begin
                gap_ok = 1;
                for (int s = 0; s < NS; s++) begin
                    if (!m_act[s] && free_idx < 0) free_idx = s;
                    if (m_act[s] && m_y[s] < MGAP) gap_ok = 0;
                end
                spawn = (rv > 32'h8000) && (m_gen < TOT) && (free_idx >= 0) && gap_ok;
            end
            for (int s = 0; s < NS; s++) begin
                if (m_act[s]) begin
                    if (hit_slot[s]) m_act[s] = 0;
                    else if (tick) begin
                        if (m_y[s] >= YMAX) begin
                            m_act[s] = 0; m_misses++; e.miss = 1'b1;
                        end else begin
                            m_y[s]++;
                        end
                    end
                end
            end
            if (spawn) begin
                m_act[free_idx] = 1; m_y[free_idx] = 0; m_col[free_idx] = rv % NC; m_gen++;
            end
        end
        if (sum == TOT) m_go = 1;
        for (int s = 0; s < NS; s++) begin
            e.act[s] = m_act[s];
            e.col[s*CW +: CW] = CW'(m_col[s]);
            e.y[s*YW +: YW] = YW'(m_y[s]);
        end
        e.hits = CNTW'(m_hits);
        e.misses = CNTW'(m_misses);
        e.gen = CNTW'(m_gen);
        e.go = m_go;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the model's prediction.
    task automatic drive_cycle(input bit st, input int spd, input logic [15:0] rv,
                               input logic [NC-1:0] kp);
        exp_t e;
        @(negedge clk);
        start = st; speed = 20'(spd); rand_val = rv; key_press = kp;
        model_step(st, spd, int'(rv), kp, e);
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_active"}, 64'(slot_active), 64'd0);
        chk({tag, "_col"}, 64'(slot_col), 64'd0);
        chk({tag, "_y"}, 64'(slot_y), 64'd0);
        chk({tag, "_hit"}, 64'(hit_pulse), 64'd0);
        chk({tag, "_bad"}, 64'(bad_press), 64'd0);
        chk({tag, "_miss"}, 64'(miss_pulse), 64'd0);
        chk({tag, "_hits"}, 64'(hits_total), 64'd0);
        chk({tag, "_misses"}, 64'(misses_total), 64'd0);
        chk({tag, "_gen"}, 64'(notes_generated), 64'd0);
        chk({tag, "_go"}, 64'(game_over), 64'd0);
    endtask

    // Asynchronous reset mid-cycle, away from both clock edges.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero(tag);
        start = 1'b0;
        key_press = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [NC-1:0] rand_keys();
        logic [NC-1:0] k;
        for (int c = 0; c < NC; c++) k[c] = ($urandom_range(0, 5) == 0);
        return k;
    endfunction

    function automatic logic [15:0] rand_lfsr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h8000;
        if (r == 1) return 16'h8001;
        return 16'($urandom);
    endfunction

    // Monitor: every DUT output update is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("slot_active", 64'(slot_active), 64'(e.act));
                chk("slot_col", 64'(slot_col), 64'(e.col));
                chk("slot_y", 64'(slot_y), 64'(e.y));
                chk("hit_pulse", 64'(hit_pulse), 64'(e.hit));
                chk("bad_press", 64'(bad_press), 64'(e.bad));
                chk("miss_pulse", 64'(miss_pulse), 64'(e.miss));
                chk("hits_total", 64'(hits_total), 64'(e.hits));
                chk("misses_total", 64'(misses_total), 64'(e.misses));
                chk("notes_generated", 64'(notes_generated), 64'(e.gen));
                chk("game_over", 64'(game_over), 64'(e.go));
            end
        end
    end

    initial begin
        int spd;
        int cyc;
        model_reset();
        do_reset("reset");

        // Constant rand above threshold, speed 0, no presses.
        drive_cycle(1'b1, 0, 16'h8001, '0);
        @(posedge clk);
        #2;
        chk("first_spawn_active", 64'(slot_active), 64'h1);
        chk("first_spawn_col", 64'(slot_col[1:0]), 64'h1);
        chk("first_spawn_gen", 64'(notes_generated), 64'h1);
        for (int i = 0; i < 70; i++) drive_cycle(1'b1, 0, 16'h8001, '0);

        // Randomized play until game over.
        spd = 0;
        cyc = 0;
        while (game_over !== 1'b1 && cyc < 20000) begin
            if (cyc % 64 == 0) spd = $urandom_range(0, 2);
            drive_cycle(($urandom_range(0, 15) != 0), spd, rand_lfsr(), rand_keys());
            cyc++;
        end
        chk("game_over_reached", 64'(game_over), 64'h1);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 0, 16'hFFFF, rand_keys());
        @(posedge clk);
        #2;
        chk("resolved_sum", 64'(hits_total) + 64'(misses_total), 64'(TOT));
        chk("all_generated", 64'(notes_generated), 64'(TOT));

        // Fresh game, then reset in the middle of it.
        do_reset("reset2");
        for (int i = 0; i < 150; i++) drive_cycle(1'b1, $urandom_range(0, 1), rand_lfsr(), rand_keys());
        do_reset("midgame");
        for (int i = 0; i < 30; i++) drive_cycle(1'b1, 0, rand_lfsr(), rand_keys());
        @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
